// File: rtl/i2c_seq_pkg.sv
// Shared constants for the iicmb_m_wb command sequencer: register map,
// controller command codes, CMDR status bits, completion codes and FSM states.
package i2c_seq_pkg;

  localparam logic [1:0] REG_CSR  = 2'd0;
  localparam logic [1:0] REG_DPR  = 2'd1;
  localparam logic [1:0] REG_CMDR = 2'd2;
  localparam logic [1:0] REG_FSMR = 2'd3;

  localparam logic [2:0] CMD_WAIT     = 3'b000;
  localparam logic [2:0] CMD_WRITE    = 3'b001;
  localparam logic [2:0] CMD_READ_ACK = 3'b010;
  localparam logic [2:0] CMD_READ_NAK = 3'b011;
  localparam logic [2:0] CMD_START    = 3'b100;
  localparam logic [2:0] CMD_STOP     = 3'b101;
  localparam logic [2:0] CMD_SET_BUS  = 3'b110;

  localparam int ST_DON = 7;
  localparam int ST_NAK = 6;
  localparam int ST_AL  = 5;
  localparam int ST_ERR = 4;

  localparam logic [7:0] CSR_ENABLE = 8'hC0;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NAK  = 2'b01;
  localparam logic [1:0] ERR_AL   = 2'b10;
  localparam logic [1:0] ERR_CTRL = 2'b11;

  typedef enum logic [3:0] {
    S_RESET_EN, S_IDLE, S_SETBUS, S_START, S_ADDR,
    S_WBYTE, S_RBYTE, S_RDPR, S_STOP, S_WAIT, S_DONE
  } seq_state_e;

  function automatic logic [7:0] cmd_byte(input logic [2:0] c);
    return {5'b0, c};
  endfunction

endpackage

// File: rtl/i2c_seq_wb_beat.sv
// Single-beat Wishbone master: i_start launches one access when idle, o_done
// pulses the cycle after ack, o_rdata holds the last read value until the next read.
module i2c_seq_wb_beat #(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          i_start,
  input  logic          i_we,
  input  logic [AW-1:0] i_adr,
  input  logic [DW-1:0] i_dat,
  output logic          o_done,
  output logic [DW-1:0] o_rdata,
  output logic          o_cyc,
  output logic          o_stb,
  output logic          o_we,
  output logic [AW-1:0] o_adr,
  output logic [DW-1:0] o_dat,
  input  logic [DW-1:0] i_wb_dat,
  input  logic          i_ack
);

  logic          r_cyc, r_we, r_done;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_dat, r_rdata;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_rdata <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_cyc) begin
        if (i_ack) begin
          r_cyc  <= 1'b0;
          r_done <= 1'b1;
          if (!r_we) r_rdata <= i_wb_dat;
        end
      end else if (i_start) begin
        r_cyc <= 1'b1;
        r_we  <= i_we;
        r_adr <= i_adr;
        r_dat <= i_dat;
      end
    end
  end

  assign o_cyc   = r_cyc;
  assign o_stb   = r_cyc;
  assign o_we    = r_we;
  assign o_adr   = r_adr;
  assign o_dat   = r_dat;
  assign o_done  = r_done;
  assign o_rdata = r_rdata;

endmodule

// File: rtl/i2c_wb_sequencer.sv
// Expands one high-level I2C transaction into the iicmb_m_wb register sequence
// (set bus, start, address, data, stop), polling CMDR for completion.
module i2c_wb_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int WB_ADDR_WIDTH = 2,
  parameter int WB_DATA_WIDTH = 8,
  parameter int LEN_WIDTH     = 6,
  parameter bit USE_IRQ       = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [3:0]               req_bus_i,
  input  logic [6:0]               req_addr_i,
  input  logic                     req_rd_i,
  input  logic [LEN_WIDTH-1:0]     req_len_i,
  input  logic                     wdata_valid_i,
  output logic                     wdata_ready_o,
  input  logic [7:0]               wdata_i,
  output logic                     rdata_valid_o,
  input  logic                     rdata_ready_i,
  output logic [7:0]               rdata_o,
  output logic                     done_o,
  output logic [1:0]               err_o,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     ack_i,
  input  logic                     irq_i
);

  localparam int CW = LEN_WIDTH + 1;

  seq_state_e r_state, r_phase;
  logic          r_pend, r_step, r_rd, r_rvalid;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bus;
  logic [6:0]    r_addr;
  logic [1:0]    r_err;
  logic [7:0]    r_rbyte;

  logic                     w_start, w_we, w_done, w_last;
  logic [WB_ADDR_WIDTH-1:0] w_adr;
  logic [WB_DATA_WIDTH-1:0] w_dat, w_rdata;

  assign w_last = (r_cnt == CW'(1));

  // r_pend marks a beat in flight; r_step selects DPR (0) or CMDR (1) in two-beat phases
  always_comb begin
    w_start = 1'b0;
    w_we    = 1'b1;
    w_adr   = WB_ADDR_WIDTH'(REG_CMDR);
    w_dat   = '0;
    case (r_state)
      S_RESET_EN: begin
        w_start = !r_pend;
        w_adr   = WB_ADDR_WIDTH'(REG_CSR);
        w_dat   = WB_DATA_WIDTH'(CSR_ENABLE);
      end
      S_SETBUS: begin
        w_start = !r_pend;
        if (!r_step) begin
          w_adr = WB_ADDR_WIDTH'(REG_DPR);
          w_dat = WB_DATA_WIDTH'({4'h0, r_bus});
        end else w_dat = WB_DATA_WIDTH'(cmd_byte(CMD_SET_BUS));
      end
      S_START: begin
        w_start = !r_pend;
        w_dat   = WB_DATA_WIDTH'(cmd_byte(CMD_START));
      end
      S_ADDR: begin
        w_start = !r_pend;
        if (!r_step) begin
          w_adr = WB_ADDR_WIDTH'(REG_DPR);
          w_dat = WB_DATA_WIDTH'({r_addr, r_rd});
        end else w_dat = WB_DATA_WIDTH'(cmd_byte(CMD_WRITE));
      end
      S_WBYTE: begin
        w_start = !r_pend && (r_step || wdata_valid_i);
        if (!r_step) begin
          w_adr = WB_ADDR_WIDTH'(REG_DPR);
          w_dat = WB_DATA_WIDTH'(wdata_i);
        end else w_dat = WB_DATA_WIDTH'(cmd_byte(CMD_WRITE));
      end
      S_RBYTE: begin
        w_start = !r_pend;
        w_dat   = WB_DATA_WIDTH'(cmd_byte(w_last ? CMD_READ_NAK : CMD_READ_ACK));
      end
      S_RDPR: begin
        w_start = !r_pend && !r_rvalid;
        w_we    = 1'b0;
        w_adr   = WB_ADDR_WIDTH'(REG_DPR);
      end
      S_STOP: begin
        w_start = !r_pend;
        w_dat   = WB_DATA_WIDTH'(cmd_byte(CMD_STOP));
      end
      S_WAIT: begin
        w_start = !r_pend && (!USE_IRQ || irq_i);
        w_we    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= S_RESET_EN;
      r_phase  <= S_IDLE;
      r_pend   <= 1'b0;
      r_step   <= 1'b0;
      r_cnt    <= '0;
      r_bus    <= '0;
      r_addr   <= '0;
      r_rd     <= 1'b0;
      r_err    <= ERR_OK;
      r_rvalid <= 1'b0;
      r_rbyte  <= '0;
    end else begin
      if (w_start) r_pend <= 1'b1;
      if (w_done)  r_pend <= 1'b0;
      case (r_state)
        S_RESET_EN: if (w_done) r_state <= S_IDLE;
        S_IDLE: if (req_valid_i) begin
          r_bus   <= req_bus_i;
          r_addr  <= req_addr_i;
          r_rd    <= req_rd_i;
          r_cnt   <= (req_len_i == '0) ? (CW'(1) << LEN_WIDTH) : {1'b0, req_len_i};
          r_err   <= ERR_OK;
          r_step  <= 1'b0;
          r_state <= S_SETBUS;
        end
        S_SETBUS, S_ADDR, S_WBYTE: if (w_done) begin
          r_step <= ~r_step;
          if (r_step) begin
            r_phase <= r_state;
            r_state <= S_WAIT;
          end
        end
        S_START, S_RBYTE, S_STOP: if (w_done) begin
          r_phase <= r_state;
          r_state <= S_WAIT;
        end
        S_RDPR: begin
          if (w_done) begin
            r_rvalid <= 1'b1;
            r_rbyte  <= w_rdata[7:0];
          end
          if (r_rvalid && rdata_ready_i) begin
            r_rvalid <= 1'b0;
            if (w_last) r_state <= S_STOP;
            else begin
              r_cnt   <= r_cnt - CW'(1);
              r_state <= S_RBYTE;
            end
          end
        end
        S_WAIT: if (w_done && (w_rdata[7:4] != 4'h0)) begin
          // a stop that itself reports trouble still ends the transaction
          if (r_phase == S_STOP) r_state <= S_DONE;
          else if (w_rdata[ST_AL]) begin
            r_err   <= ERR_AL;
            r_state <= S_DONE;
          end else if (w_rdata[ST_ERR]) begin
            r_err   <= ERR_CTRL;
            r_state <= S_STOP;
          end else if (w_rdata[ST_NAK] && (r_phase == S_ADDR || r_phase == S_WBYTE)) begin
            r_err   <= ERR_NAK;
            r_state <= S_STOP;
          end else begin
            case (r_phase)
              S_SETBUS: r_state <= S_START;
              S_START:  r_state <= S_ADDR;
              S_ADDR:   r_state <= r_rd ? S_RBYTE : S_WBYTE;
              S_RBYTE:  r_state <= S_RDPR;
              S_WBYTE: begin
                if (w_last) r_state <= S_STOP;
                else begin
                  r_cnt   <= r_cnt - CW'(1);
                  r_state <= S_WBYTE;
                end
              end
              default:  r_state <= S_DONE;
            endcase
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  i2c_seq_wb_beat #(.AW(WB_ADDR_WIDTH), .DW(WB_DATA_WIDTH)) u_beat (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .i_start  (w_start),
    .i_we     (w_we),
    .i_adr    (w_adr),
    .i_dat    (w_dat),
    .o_done   (w_done),
    .o_rdata  (w_rdata),
    .o_cyc    (cyc_o),
    .o_stb    (stb_o),
    .o_we     (we_o),
    .o_adr    (adr_o),
    .o_dat    (dat_o),
    .i_wb_dat (dat_i),
    .i_ack    (ack_i)
  );

  assign req_ready_o   = (r_state == S_IDLE);
  assign wdata_ready_o = (r_state == S_WBYTE) && !r_step && !r_pend && wdata_valid_i;
  assign rdata_valid_o = r_rvalid;
  assign rdata_o       = r_rbyte;
  assign done_o        = (r_state == S_DONE);
  assign err_o         = done_o ? r_err : ERR_OK;

endmodule
